mcpu5_host_sequencer: RTL and testbench

Host-side companion to the MCPU5 core: holds a 64-word program store, generates the core's clock and reset, and reads the multiplexed core output bus. While the core clock is high the bus carries the program counter. The block fetches the 6-bit instruction for that address and drives it back to the core. While the core clock is low the bus carries the accumulator; the block captures it into a handshaked output register whenever an OUT instruction executes. It sits directly upstream of the core as its instruction source, and directly downstream of it as the consumer of `cpu_out`.

---
 rtl/mcpu5_host_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mcpu5_host_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu5_host_sequencer.sv
// Host-side sequencer for the MCPU5 core: program store, core clock/reset
// generation, instruction fetch from the PC phase and OUT capture from the accumulator phase.
module mcpu5_host_sequencer #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic       run,
  output logic       cpu_clk,
  output logic       cpu_rst,
  output logic [5:0] cpu_inst,
  input  logic [7:0] cpu_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       halted
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF    = CW'(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_DIV - 1);
  localparam logic [5:0]    OP_OUT  = 6'b111001;

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_HIGH, S_LOW, S_STALL} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_cpu_clk, r_cpu_rst;
  logic [5:0]    r_cpu_inst;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_halted;
  logic [5:0]    r_load_addr;
  logic [5:0]    r_pc_q;
  logic          r_pc_valid;
  logic [5:0]    r_mem [64];

  logic w_load, w_fetch, w_capture, w_to_idle;
  logic w_cpu_clk_next, w_cpu_rst_next;

  assign w_load  = (r_state == S_IDLE) && load_valid && !run;
  assign w_fetch = (r_state == S_HIGH) && (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_to_idle    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_next = S_CRST;
          w_cnt_next   = '0;
        end
      end
      S_CRST: begin
        if (r_cnt == FULL_M1) begin
          w_state_next = S_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_HIGH: begin
        if (r_cnt == HALF_M1) begin
          w_state_next = S_LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_LOW: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_next = '0;
          // An OUT that would overwrite an unconsumed value parks the core instead.
          if (r_cpu_inst == OP_OUT && r_out_valid && !out_ready) begin
            w_state_next = S_STALL;
          end else begin
            w_capture = (r_cpu_inst == OP_OUT);
            if (run) begin
              w_state_next = S_HIGH;
            end else begin
              w_state_next = S_IDLE;
              w_to_idle    = 1'b1;
            end
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_STALL: begin
        if (out_ready) begin
          w_capture = 1'b1;
          if (run) begin
            w_state_next = S_HIGH;
          end else begin
            w_state_next = S_IDLE;
            w_to_idle    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    w_cpu_clk_next = (w_state_next == S_HIGH) ||
                     ((w_state_next == S_CRST) && (w_cnt_next < HALF));
    w_cpu_rst_next = (w_state_next == S_IDLE) || (w_state_next == S_CRST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cpu_clk   <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_cpu_inst  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_load_addr <= '0;
      r_pc_q      <= '0;
      r_pc_valid  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cpu_clk <= w_cpu_clk_next;
      r_cpu_rst <= w_cpu_rst_next;
      if (w_load) begin
        r_load_addr <= r_load_addr + 6'd1;
      end
      if (w_fetch) begin
        r_cpu_inst <= r_mem[cpu_out[5:0]];
        r_pc_q     <= cpu_out[5:0];
        r_pc_valid <= 1'b1;
        if (r_pc_valid && (cpu_out[5:0] == r_pc_q)) begin
          r_halted <= 1'b1;
        end
      end
      if (w_to_idle) begin
        r_cpu_inst  <= '0;
        r_pc_valid  <= 1'b0;
        r_halted    <= 1'b0;
        r_load_addr <= '0;
      end
      // A capture takes priority over a simultaneous consume.
      if (w_capture) begin
        r_out_data  <= cpu_out;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Program store has no reset so its contents survive rst and run/stop.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[r_load_addr] <= load_data;
    end
  end

  assign load_ready = (r_state == S_IDLE) && !run;
  assign cpu_clk    = r_cpu_clk;
  assign cpu_rst    = r_cpu_rst;
  assign cpu_inst   = r_cpu_inst;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign halted     = r_halted;
endmodule

// File: tb/tb_mcpu5_host_sequencer.sv
// Bench for mcpu5_host_sequencer: a stand-in core drives cpu_out, and a cycle-position
// model derived from the sequencing rules is compared against the DUT every clock.
module tb_mcpu5_host_sequencer;
  localparam int D = 2;
  localparam logic [5:0] OP_OUT = 6'h39;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       run = 1'b0;
  logic       cpu_clk, cpu_rst;
  logic [5:0] cpu_inst;
  logic [7:0] cpu_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       halted;

  mcpu5_host_sequencer #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .run(run), .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .cpu_inst(cpu_inst), .cpu_out(cpu_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Stand-in core: scripted PC sequence (accu fixed at 5) or random PC/accu.
  logic [5:0] core_pc = '0;
  logic [7:0] core_acc = '0;
  logic       core_random = 1'b0;
  logic [5:0] seq [8];
  int         seq_len = 1, seq_loop = 0, seq_idx = 0;

  assign cpu_out = cpu_clk ? {2'b00, core_pc} : core_acc;

  always @(posedge cpu_clk) begin
    if (cpu_rst) begin
      seq_idx <= 0;
    end else if (core_random) begin
      if ($urandom_range(0, 3) != 0) core_pc <= 6'($urandom_range(0, 63));
      core_acc <= 8'($urandom);
    end else begin
      core_pc  <= seq[seq_idx];
      seq_idx  <= (seq_idx == seq_len - 1) ? seq_loop : seq_idx + 1;
      core_acc <= 8'h05;
    end
  end

  // Reference model: position n counts non-stalled clocks since run was accepted.
  logic       m_running, m_stall;
  int         m_n;
  logic [5:0] m_inst;
  logic       m_inst_known;
  logic [7:0] m_out_data;
  logic       m_out_valid, m_halted;
  logic [5:0] m_pc_last;
  logic       m_pc_valid;
  logic [5:0] m_la;
  logic [5:0] mem_m [64];
  logic       mem_known [64];

  task automatic m_stop();
    m_running = 1'b0; m_stall = 1'b0; m_n = 0;
    m_inst = '0; m_inst_known = 1'b1; m_halted = 1'b0;
    m_pc_valid = 1'b0; m_la = '0;
  endtask

  task automatic m_reset();
    m_stop();
    m_out_data = '0; m_out_valid = 1'b0; m_pc_last = '0;
  endtask

  task automatic m_step();
    int   ph;
    logic cap;
    cap = 1'b0;
    if (!m_running) begin
      if (run) begin
        m_running = 1'b1; m_n = 0;
      end else if (load_valid) begin
        mem_m[m_la] = load_data; mem_known[m_la] = 1'b1; m_la = m_la + 6'd1;
      end
    end else if (m_stall) begin
      if (out_ready) begin
        cap = 1'b1; m_stall = 1'b0; m_n++;
        if (!run) m_stop();
      end
    end else begin
      ph = m_n % (2 * D);
      if (m_n >= 2 * D && ph == 0) begin
        if (m_pc_valid && cpu_out[5:0] == m_pc_last) m_halted = 1'b1;
        m_pc_last = cpu_out[5:0]; m_pc_valid = 1'b1;
        m_inst = mem_m[cpu_out[5:0]]; m_inst_known = mem_known[cpu_out[5:0]];
      end
      if (m_n >= 2 * D && ph == 2 * D - 1) begin
        if (m_inst == OP_OUT && m_out_valid && !out_ready) begin
          m_stall = 1'b1;
        end else begin
          cap = (m_inst == OP_OUT); m_n++;
          if (!run) m_stop();
        end
      end else begin
        m_n++;
      end
    end
    if (cap) begin
      m_out_data = cpu_out; m_out_valid = 1'b1;
    end else if (m_out_valid && out_ready) begin
      m_out_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) m_reset();
    check("cpu_clk", cpu_clk, m_running && !m_stall && ((m_n % (2 * D)) < D));
    check("cpu_rst", cpu_rst, !m_running || (m_n < 2 * D));
    if (m_inst_known) check("cpu_inst", cpu_inst, m_inst);
    check("out_data", out_data, m_out_data);
    check("out_valid", out_valid, m_out_valid);
    check("halted", halted, m_halted);
    check("load_ready", load_ready, !m_running && !run);
    if (!rst) m_step();
  end

  // Logs of instruction changes and presented output values for the literal checks.
  logic       log_en = 1'b0;
  logic [5:0] last_logged = '0;
  logic [5:0] inst_log [$];
  int         cap_good = 0, cap_bad = 0;

  always @(negedge clk) begin
    if (log_en) begin
      if (cpu_inst != last_logged) inst_log.push_back(cpu_inst);
      last_logged = cpu_inst;
      if (out_valid) begin
        if (out_data == 8'h05) cap_good++;
        else cap_bad++;
      end
    end
  end

  function automatic logic [7:0] log_at(input int i);
    return (i < inst_log.size()) ? 8'(inst_log[i]) : 8'hFF;
  endfunction

  task automatic start_log();
    inst_log.delete(); last_logged = '0; cap_good = 0; cap_bad = 0; log_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic load_word(input logic [5:0] w);
    load_valid = 1'b1; load_data = w; tick(); load_valid = 1'b0;
  endtask

  task automatic set_seq(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                         input int len, input int loop_to);
    seq[0] = a; seq[1] = b; seq[2] = c; seq_len = len; seq_loop = loop_to;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!load_ready && k < 200) begin tick(); k++; end
    check(name, load_ready, 1);
  endtask

  task automatic wait_stall(input string name);
    int k, lows;
    k = 0; lows = 0;
    while (lows <= 2 * D && k < 200) begin
      tick(); k++;
      lows = cpu_clk ? 0 : lows + 1;
    end
    check(name, lows > 2 * D, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem_m[i] = '0; mem_known[i] = 1'b0; end
    m_reset();
    repeat (3) tick();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_clk", cpu_clk, 0);
    check("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    repeat (10) tick();
    check("idle_load_ready", load_ready, 1);
    check("idle_cpu_rst", cpu_rst, 1);
    check("idle_cpu_clk", cpu_clk, 0);
    $display("[TB] reset/idle phase done");

    load_word(6'h15); load_word(6'h39); load_word(6'h0F);
    set_seq(6'd0, 6'd1, 6'd2, 3, 1);
    out_ready = 1'b1;
    start_log();
    run = 1'b1;
    repeat (41) tick();
    run = 1'b0;
    wait_idle("loop_stop");
    log_en = 1'b0;
    check("loop_inst0", log_at(0), 8'h15);
    check("loop_inst1", log_at(1), 8'h39);
    check("loop_inst2", log_at(2), 8'h0F);
    check("loop_inst3", log_at(3), 8'h39);
    check("loop_out_pulses", cap_good >= 3, 1);
    check("loop_out_bad", cap_bad, 0);
    $display("[TB] load+loop phase done, %0d outputs seen", cap_good);

    out_ready = 1'b0;
    run = 1'b1;
    wait_stall("bp_stall");
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 8'h05);
    check("bp_clk_low", cpu_clk, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_resume_clk", cpu_clk, 1);
    check("bp_resume_valid", out_valid, 1);
    run = 1'b0; out_ready = 1'b1;
    wait_idle("bp_stop");
    $display("[TB] backpressure phase done");

    load_word(6'h15); load_word(6'h39); load_word(6'h00);
    set_seq(6'd0, 6'd1, 6'd2, 3, 2);
    run = 1'b1;
    repeat (16) tick();
    check("halt_not_yet", halted, 0);
    repeat (14) tick();
    check("halt_set", halted, 1);
    run = 1'b0;
    wait_idle("halt_stop");
    check("halt_clear", halted, 0);
    $display("[TB] halt phase done");

    for (int i = 0; i < 64; i++) load_word(6'(i));
    load_word(6'h2A);
    set_seq(6'd0, 6'd0, 6'd0, 1, 0);
    run = 1'b1;
    repeat (10) tick();
    check("wrap_mem0", cpu_inst, 6'h2A);
    run = 1'b0;
    wait_idle("wrap_stop0");
    set_seq(6'd1, 6'd1, 6'd1, 1, 0);
    run = 1'b1;
    repeat (10) tick();
    check("wrap_mem1", cpu_inst, 6'h01);
    run = 1'b0;
    wait_idle("wrap_stop1");
    $display("[TB] load wrap phase done");

    load_word(6'h15); load_word(6'h39); load_word(6'h0F);
    set_seq(6'd0, 6'd1, 6'd2, 3, 1);
    out_ready = 1'b0;
    run = 1'b1;
    wait_stall("rs_stall");
    rst = 1'b1;
    #1;
    check("rs_cpu_clk", cpu_clk, 0);
    check("rs_cpu_rst", cpu_rst, 1);
    check("rs_out_valid", out_valid, 0);
    run = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rs_idle", load_ready, 1);
    out_ready = 1'b1;
    start_log();
    run = 1'b1;
    repeat (20) tick();
    run = 1'b0;
    wait_idle("rs_stop");
    log_en = 1'b0;
    check("rs_prog_inst0", log_at(0), 8'h15);
    check("rs_prog_inst1", log_at(1), 8'h39);
    $display("[TB] async reset phase done");

    core_random = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) run = ~run;
      out_ready  = ($urandom_range(0, 1) == 1);
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = 6'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      tick();
    end
    run = 1'b0; load_valid = 1'b0; out_ready = 1'b1;
    wait_idle("rand_stop");
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
